image_job_scheduler: RTL and testbench
======================================

# image_job_scheduler

Sequencer and round-robin arbiter sharing one `image_processor_bram` among NUM_REQ client requesters. Each client posts a job (operation plus one 8-bit parameter). The scheduler grants one job at a time and drives the processor's start/config inputs. It waits for processor completion under a watchdog, then returns a per-client completion pulse. It sits between the client front-ends and the processor core.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 1048576, watchdog limit in WAIT; must exceed the worst-case frame time (3·IMAGE_SIZE+4 cycles)
- TMR_W, 21, watchdog counter width; 2^TMR_W must be greater than TIMEOUT_CYCLES
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-client job request, level; held until that client's job_done
- req_op  in  2·NUM_REQ  client i opcode at [2i+1:2i]
- req_param  in  8·NUM_REQ  client i parameter at [8i+7:8i]
- grant  out  NUM_REQ  one-hot owner of the running job, else 0
- job_done  out  NUM_REQ  one-cycle pulse to the owner at job end
- job_err  out  1  one-cycle pulse, coincident with job_done, when the job ended by timeout
- fault  out  1  sticky; set on any timeout; cleared only by reset
- busy  out  1  high in every state except IDLE
- proc_start  out  1  one-cycle start pulse to processor
- proc_operation_select  out  2  latched opcode
- proc_threshold_value  out  8  latched parameter when op=01, else 0
- proc_brightness_value  out  8  latched parameter when op=10, else 0
- proc_done  in  1  processor completion pulse

## Operation
- States: IDLE, GRANT, START, WAIT, FINISH.
- IDLE:
  - If any req bit is high, pick a winner round-robin, starting the search at pointer rr_ptr.
  - Latch the winner's op and param, assert its grant bit, and go to GRANT.
- GRANT: drive the proc_* config outputs from the latched values; go to START.
- START: proc_start=1 for this cycle only; clear the watchdog; go to WAIT.
- WAIT: increment the watchdog every cycle.
  - If proc_done=1, go to FINISH (normal end).
  - Otherwise, if the watchdog count equals TIMEOUT_CYCLES-1, go to FINISH with err flagged.
  - proc_done has priority when both occur in the same cycle.
- FINISH:
  - Pulse job_done[owner], plus job_err if err was flagged; set fault if err was flagged.
  - Deassert grant.
  - Set rr_ptr to (owner+1) mod NUM_REQ and go to IDLE.
- Opcodes: 00 invert, 01 threshold, 10 brightness (param is two's-complement offset), 11 grayscale.
- The proc_* config outputs hold their latched values until the next GRANT.
- proc_done outside WAIT is ignored. This covers a late done after a timeout and a spurious done in IDLE.
- Client dropping req after grant:
  - The job is not aborted.
  - job_done is still pulsed to that client.
- Client dropping req before grant: not served; no pulse.
- req/op/param are sampled only in the IDLE decision cycle. Changes later have no effect on the running job.
- A client re-asserting req right after its job_done waits its round-robin turn behind the other pending clients.

## Timing
- Reset (asynchronous, rst_n=0) forces:
  - state=IDLE, rr_ptr=0, watchdog=0;
  - grant=0, job_done=0, job_err=0, fault=0, busy=0, proc_start=0;
  - proc_* config outputs = 0.
- Reset mid-job drops everything immediately; the processor must be reset alongside.
- Latency, with req seen high in IDLE at cycle 0:
  - grant and busy high at cycle 1;
  - proc_start high during cycle 2;
  - proc_done at cycle N gives job_done at cycle N+1;
  - IDLE at cycle N+2, so the next grant comes no earlier than N+3.
- Timeout:
  - job_done/job_err assert exactly TIMEOUT_CYCLES cycles after the first WAIT cycle;
  - fault is high from that cycle onward.
- All outputs are registered.

## Structure
- Shared package `image_proc_pkg`:
  - opcode constants OP_INVERT, OP_THRESH, OP_BRIGHT, OP_GRAY;
  - scheduler state encoding;
  - default TIMEOUT_CYCLES.
- Sub-module `image_job_rr_arbiter`: combinational; inputs req and rr_ptr; outputs a one-hot winner and a valid flag. It is reused by any future shared-resource front-end.

## Test plan
- Single client: req=0001, op=01, param=0x80; the processor model returns done 20 cycles after start.
  - Required: proc_threshold_value=0x80, proc_brightness_value=0, exactly one proc_start, job_done=0001 one cycle after done, job_err=0.
- All four clients request together from reset.
  - Required: grant order 0,1,2,3; each gets exactly one job_done; no grant overlap.
- Fairness:
  - Clients 0 and 2 request continuously; required order 0,2,0,2.
  - Client 1 joins while client 2 is running; required order after 2 is 0 then 1.
- Timeout: TIMEOUT_CYCLES=64 and no proc_done.
  - Required: job_done and job_err pulse 64 cycles after the first WAIT cycle; fault stays high.
  - A proc_done then arriving in IDLE is ignored.
- Reset mid-WAIT: rst_n low for 3 cycles.
  - Required: all outputs at their reset values asynchronously.
  - A req arriving after release is granted to client rr_ptr=0 first.

Source files
------------

// File: rtl/image_proc_pkg.sv
// Shared definitions for the image processor front-end: opcodes, scheduler
// state encoding and the default watchdog limit.
package image_proc_pkg;

    localparam logic [1:0] OP_INVERT = 2'b00;
    localparam logic [1:0] OP_THRESH = 2'b01;
    localparam logic [1:0] OP_BRIGHT = 2'b10;
    localparam logic [1:0] OP_GRAY   = 2'b11;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1048576;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } sched_state_t;

endpackage

// File: rtl/image_job_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after rr_ptr
// (wrapping) wins; the winner is returned one-hot.
module image_job_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] rot_oh;

    // Rotate so rr_ptr sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        rot    = NUM_REQ'({req, req} >> rr_ptr);
        rot_oh = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                rot_oh    = '0;
                rot_oh[k] = 1'b1;
            end
        end
        winner = NUM_REQ'(({rot_oh, rot_oh} << rr_ptr) >> NUM_REQ);
    end

    assign valid = |req;

endmodule

// File: rtl/image_job_scheduler.sv
// Sequences jobs from NUM_REQ clients onto one image processor, round-robin,
// with a watchdog on processor completion.
module image_job_scheduler
    import image_proc_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TMR_W          = 21
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_op,
    input  logic [8*NUM_REQ-1:0]   req_param,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     job_done,
    output logic                   job_err,
    output logic                   fault,
    output logic                   busy,
    output logic                   proc_start,
    output logic [1:0]             proc_operation_select,
    output logic [7:0]             proc_threshold_value,
    output logic [7:0]             proc_brightness_value,
    input  logic                   proc_done
);

    localparam int               PTR_W    = $clog2(NUM_REQ);
    localparam logic [TMR_W-1:0] WD_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

    sched_state_t       state, next_state;
    logic [PTR_W-1:0]   rr_ptr, owner, next_ptr;
    logic [NUM_REQ-1:0] winner;
    logic               win_valid;
    logic [1:0]         win_op, op_q;
    logic [7:0]         win_param, param_q;
    logic [TMR_W-1:0]   wd;
    logic               wd_expired;

    image_job_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        win_op    = '0;
        win_param = '0;
        owner     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                win_op    = req_op[2*i +: 2];
                win_param = req_param[8*i +: 8];
            end
            if (grant[i]) owner = PTR_W'(i);
        end
    end

    assign next_ptr   = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
    assign wd_expired = (wd == WD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (win_valid) next_state = ST_GRANT;
            ST_GRANT:  next_state = ST_START;
            ST_START:  next_state = ST_WAIT;
            ST_WAIT:   if (proc_done || wd_expired) next_state = ST_FINISH;
            ST_FINISH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Registered outputs; job_done/job_err land in the FINISH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr                <= '0;
            wd                    <= '0;
            grant                 <= '0;
            job_done              <= '0;
            job_err               <= 1'b0;
            fault                 <= 1'b0;
            busy                  <= 1'b0;
            proc_start            <= 1'b0;
            op_q                  <= '0;
            param_q               <= '0;
            proc_operation_select <= '0;
            proc_threshold_value  <= '0;
            proc_brightness_value <= '0;
        end else begin
            job_done   <= '0;
            job_err    <= 1'b0;
            proc_start <= 1'b0;
            busy       <= (next_state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        grant   <= winner;
                        op_q    <= win_op;
                        param_q <= win_param;
                    end
                end
                ST_GRANT: begin
                    proc_operation_select <= op_q;
                    proc_threshold_value  <= (op_q == OP_THRESH) ? param_q : 8'h00;
                    proc_brightness_value <= (op_q == OP_BRIGHT) ? param_q : 8'h00;
                    proc_start            <= 1'b1;
                end
                ST_START: wd <= '0;
                ST_WAIT: begin
                    wd <= wd + TMR_W'(1);
                    // A done in the expiry cycle still counts as a clean finish.
                    if (proc_done || wd_expired) begin
                        job_done <= grant;
                        job_err  <= !proc_done;
                        if (!proc_done) fault <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    grant  <= '0;
                    rr_ptr <= next_ptr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_image_job_scheduler.sv
// Scoreboard bench for image_job_scheduler with a delayed-done processor model.
module tb_image_job_scheduler;

    logic        clk, rst_n;
    logic [3:0]  req;
    logic [7:0]  req_op;
    logic [31:0] req_param;
    logic [3:0]  grant, job_done;
    logic        job_err, fault, busy, proc_start;
    logic [1:0]  proc_operation_select;
    logic [7:0]  proc_threshold_value, proc_brightness_value;
    logic        proc_done, model_done, spur_done;

    assign proc_done = model_done | spur_done;

    image_job_scheduler #(.NUM_REQ(4), .TIMEOUT_CYCLES(64), .TMR_W(21)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req                   (req),
        .req_op                (req_op),
        .req_param             (req_param),
        .grant                 (grant),
        .job_done              (job_done),
        .job_err               (job_err),
        .fault                 (fault),
        .busy                  (busy),
        .proc_start            (proc_start),
        .proc_operation_select (proc_operation_select),
        .proc_threshold_value  (proc_threshold_value),
        .proc_brightness_value (proc_brightness_value),
        .proc_done             (proc_done)
    );

    typedef struct { logic [3:0] g; logic [1:0] op; logic [7:0] thr; logic [7:0] bri; } gexp_t;
    typedef struct { logic [3:0] d; logic err; } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, start_count = 0;
    int last_start_cyc = 0, last_done_cyc = 0;
    int model_delay = 20;
    bit model_en = 1;

    // Hand-computed per-client config: client0 thresh 0x80, client1 invert,
    // client2 brightness 0xF6 (-10), client3 grayscale.
    logic [1:0] e_op [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [7:0] e_thr[4] = '{8'h80, 8'h00, 8'h00, 8'h00};
    logic [7:0] e_bri[4] = '{8'h00, 8'h00, 8'hF6, 8'h00};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_grant(input int c);
        gexp_t e;
        e.g = 4'b0001 << c; e.op = e_op[c]; e.thr = e_thr[c]; e.bri = e_bri[c];
        gq.push_back(e);
    endtask

    task automatic expect_done(input int c, input logic err);
        dexp_t e;
        e.d = 4'b0001 << c; e.err = err;
        dq.push_back(e);
    endtask

    task automatic wait_done(input logic [3:0] drop, input int budget);
        int t = 0;
        do begin @(negedge clk); t++; end while (job_done == 4'b0 && t < budget);
        if (job_done == 4'b0) check("job_done_wait_expired", 32'd0, 32'd1);
        req = req & ~drop;
    endtask

    task automatic wait_grant(input logic [3:0] g, input int budget);
        int t = 0;
        do begin @(negedge clk); t++; end while (grant != g && t < budget);
        check("grant_wait", grant, g);
    endtask

    // Processor model: done pulse model_delay cycles after a start.
    initial begin
        int cnt = 0;
        bit pend = 0;
        model_done = 1'b0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (!rst_n) pend = 0;
            else if (pend) begin
                cnt--;
                if (cnt == 0) begin model_done = 1'b1; pend = 0; last_done_cyc = cyc; end
            end
            if (proc_start && rst_n) begin
                last_start_cyc = cyc;
                if (model_en) begin pend = 1; cnt = model_delay; end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant, start or done.
    initial begin
        gexp_t cur;
        dexp_t de;
        logic [3:0] prev_grant = '0;
        cur.g = '0; cur.op = '0; cur.thr = '0; cur.bri = '0;
        forever begin
            @(negedge clk);
            if (grant != 4'b0 && grant != prev_grant) begin
                check("grant_onehot", 32'($onehot(grant)), 32'd1);
                if (gq.size() == 0) check("unexpected_grant", grant, 32'd0);
                else begin
                    cur = gq.pop_front();
                    check("grant_order", grant, cur.g);
                end
            end
            prev_grant = grant;
            if (proc_start) begin
                start_count++;
                check("proc_op", proc_operation_select, cur.op);
                check("proc_thresh", proc_threshold_value, cur.thr);
                check("proc_bright", proc_brightness_value, cur.bri);
            end
            if (job_done != 4'b0) begin
                if (dq.size() == 0) check("unexpected_job_done", job_done, 32'd0);
                else begin
                    de = dq.pop_front();
                    check("job_done_vec", job_done, de.d);
                    check("job_err", job_err, de.err);
                    if (de.err) check("timeout_latency", cyc, last_start_cyc + 65);
                    else        check("done_latency", cyc, last_done_cyc + 1);
                end
            end else if (job_err) check("job_err_alone", job_err, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        int s0;
        rst_n = 1'b0; req = '0; spur_done = 1'b0;
        req_op    = {2'b11, 2'b10, 2'b00, 2'b01};
        req_param = {8'h33, 8'hF6, 8'hAA, 8'h80};
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);      check("rst_job_done", job_done, 0);
        check("rst_job_err", job_err, 0);  check("rst_fault", fault, 0);
        check("rst_busy", busy, 0);        check("rst_proc_start", proc_start, 0);
        check("rst_op", proc_operation_select, 0);
        check("rst_thr", proc_threshold_value, 0);
        check("rst_bri", proc_brightness_value, 0);
        rst_n = 1'b1;

        // Single client, threshold 0x80
        @(negedge clk);
        s0 = start_count;
        expect_grant(0); expect_done(0, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        check("t1_grant_c1", grant, 4'b0001);
        check("t1_busy_c1", busy, 1);
        @(negedge clk);
        check("t1_start_c2", proc_start, 1);
        wait_done(4'b0001, 200);
        repeat (3) @(negedge clk);
        check("t1_one_start", start_count - s0, 1);
        check("t1_fault_clear", fault, 0);
        check("t1_idle", busy, 0);

        // All four clients from reset
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin expect_grant(c); expect_done(c, 1'b0); end
        req = 4'b1111;
        for (int c = 0; c < 4; c++) wait_done(4'b0001 << c, 200);

        // Fairness: 0 and 2 continuous, client 1 joins during client 2's second job
        expect_grant(0); expect_done(0, 1'b0);
        expect_grant(2); expect_done(2, 1'b0);
        expect_grant(0); expect_done(0, 1'b0);
        expect_grant(2); expect_done(2, 1'b0);
        expect_grant(0); expect_done(0, 1'b0);
        expect_grant(1); expect_done(1, 1'b0);
        req = 4'b0101;
        repeat (3) wait_done(4'b0000, 200);
        wait_grant(4'b0100, 20);
        req[1] = 1'b1;
        wait_done(4'b0100, 200);
        wait_done(4'b0001, 200);
        wait_done(4'b0010, 200);

        // Timeout with no processor done, then a stray done in IDLE
        model_en = 0;
        expect_grant(1); expect_done(1, 1'b1);
        req = 4'b0010;
        wait_done(4'b0010, 200);
        check("to_fault_set", fault, 1);
        s0 = start_count;
        repeat (2) @(negedge clk);
        spur_done = 1'b1; @(negedge clk); spur_done = 1'b0;
        repeat (3) @(negedge clk);
        check("spur_busy", busy, 0);
        check("spur_grant", grant, 0);
        check("spur_no_start", start_count - s0, 0);
        check("fault_sticky", fault, 1);

        // Reset in the middle of WAIT
        model_en = 1; model_delay = 50;
        expect_grant(3);
        req = 4'b1000;
        wait_grant(4'b1000, 20);
        repeat (6) @(negedge clk);
        check("mid_busy_before", busy, 1);
        #2 rst_n = 1'b0; req = '0;
        #1;
        check("async_grant", grant, 0);     check("async_busy", busy, 0);
        check("async_fault", fault, 0);     check("async_job_done", job_done, 0);
        check("async_job_err", job_err, 0); check("async_start", proc_start, 0);
        check("async_op", proc_operation_select, 0);
        check("async_thr", proc_threshold_value, 0);
        check("async_bri", proc_brightness_value, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1; model_delay = 20;
        expect_grant(1); expect_done(1, 1'b0);
        expect_grant(3); expect_done(3, 1'b0);
        req = 4'b1010;
        wait_done(4'b0010, 200);
        wait_done(4'b1000, 200);
        repeat (4) @(negedge clk);

        check("grant_queue_empty", gq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
